// File: rtl/projfilt_pkg.sv
// projfilt shared types and constants
// state encoding, datapath widths, default taps
package projfilt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MAC0,
    MAC1,
    MAC2,
    OUT
  } state_t;

  localparam int SAMPLE_W = 8;
  localparam int PROD_W   = 16;
  localparam int ACC_W    = 18;
  localparam int FRAC_DEF = 6;

  localparam logic signed [7:0] C0_DEF = 8'sh40;
  localparam logic signed [7:0] C1_DEF = 8'shEC;
  localparam logic signed [7:0] C2_DEF = 8'sh09;

endpackage

// File: rtl/projfilt_inv_round_sat8.sv
// round half toward +inf, then clamp to int8
// shared with the synthesis filter
module round_sat8 #(
  parameter int ACC_W = 18,
  parameter int FRAC  = 6
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [7:0]       q
);

  localparam int QW = ACC_W - FRAC + 1;
  localparam logic signed [QW-1:0] MAXV = QW'(127);
  localparam logic signed [QW-1:0] MINV = QW'(-128);

  logic signed [QW-1:0] sh;
  logic signed [QW-1:0] rq;

  // one spare bit so the round-up cannot wrap
  assign sh = QW'(acc >>> FRAC);
  assign rq = sh + QW'(acc[FRAC-1]);

  always_comb begin
    q = rq[7:0];
    if (rq > MAXV) begin
      q = 8'sd127;
    end else if (rq < MINV) begin
      q = -8'sd128;
    end
  end

endmodule

// File: rtl/projfilt_inv.sv
// 3-tap FIR whitening filter, one shared multiplier
// three MAC cycles per sample on a valid/ready stream
module projfilt_inv
  import projfilt_pkg::*;
#(
  parameter logic signed [7:0] C0   = C0_DEF,
  parameter logic signed [7:0] C1   = C1_DEF,
  parameter logic signed [7:0] C2   = C2_DEF,
  parameter int                FRAC = FRAC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data
);

  state_t state;
  state_t state_nxt;

  logic signed [SAMPLE_W-1:0] s0;
  logic signed [SAMPLE_W-1:0] d1;
  logic signed [SAMPLE_W-1:0] d2;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    acc_nxt;

  logic signed [7:0]          coef;
  logic signed [SAMPLE_W-1:0] op;
  logic signed [PROD_W-1:0]   prod;
  logic signed [7:0]          rs;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    coef      = '0;
    op        = '0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = MAC0;
      end
      MAC0: begin
        coef      = C0;
        op        = s0;
        state_nxt = MAC1;
      end
      MAC1: begin
        coef      = C1;
        op        = d1;
        state_nxt = MAC2;
      end
      MAC2: begin
        coef      = C2;
        op        = d2;
        state_nxt = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign prod    = coef * op;
  assign acc_nxt = acc + ACC_W'(prod);

  // MAC2 result is rounded straight off the adder
  round_sat8 #(
    .ACC_W(ACC_W),
    .FRAC (FRAC)
  ) u_rs (
    .acc(acc_nxt),
    .q  (rs)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      s0       <= '0;
      d1       <= '0;
      d2       <= '0;
      acc      <= '0;
      out_data <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            s0  <= in_data;
            acc <= '0;
          end
        end
        MAC0, MAC1: acc <= acc_nxt;
        MAC2: begin
          acc      <= acc_nxt;
          d2       <= d1;
          d1       <= s0;
          out_data <= rs;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_projfilt_inv.sv
// bench for projfilt_inv: vector table, hand sequences,
// randomized samples against an arithmetic model
module tb_projfilt_inv;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       iv[3];
  logic       ir[3];
  logic       ov[3];
  logic       orr[3];
  logic [7:0] id[3];
  logic [7:0] od[3];

  int total = 0;
  int bad = 0;
  int h1 = 0;
  int h2 = 0;

  always #5 clk = ~clk;

  projfilt_inv u_def (
    .clk(clk), .reset(reset),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(orr[0]), .out_data(od[0])
  );

  projfilt_inv #(
    .C0(8'sh01), .C1(8'sh00), .C2(8'sh00)
  ) u_rnd (
    .clk(clk), .reset(reset),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(orr[1]), .out_data(od[1])
  );

  projfilt_inv #(
    .C0(8'sh7F), .C1(8'sh7F), .C2(8'sh7F)
  ) u_sat (
    .clk(clk), .reset(reset),
    .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
    .out_valid(ov[2]), .out_ready(orr[2]), .out_data(od[2])
  );

  typedef struct {
    int k;
    int y;
    int exp;
  } vec_t;

  vec_t tv[$];

  // x = round_half_up(sum c*y / 64), clamped to int8
  function automatic int model(int c0, int c1, int c2,
                               int y0, int y1, int y2);
    int acc;
    int q;
    acc = c0 * y0 + c1 * y1 + c2 * y2;
    q = int'($floor((real'(acc) + 32.0) / 64.0));
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return q;
  endfunction

  function automatic int dmodel(int y);
    return model(64, -20, 9, y, h1, h2);
  endfunction

  task automatic chk(string name, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic send(int k, int y, output int got, output int lat);
    int n;
    logic [31:0] yv;
    n = 0;
    got = 0;
    yv = y;
    while (!ir[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout got=0 exp=1");
    end
    iv[k] = 1'b1;
    id[k] = yv[7:0];
    @(negedge clk);
    iv[k] = 1'b0;
    lat = 1;
    while (!ov[k] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got = int'($signed(od[k]));
    @(negedge clk);
  endtask

  int got;
  int lat;
  int v0;
  int y;
  int e;

  initial begin
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0;
      id[i] = '0;
      orr[i] = 1'b1;
    end

    tv.push_back('{0, 64, 64});
    tv.push_back('{0, 0, -20});
    tv.push_back('{0, 0, 9});
    tv.push_back('{0, 0, 0});
    tv.push_back('{1, 32, 1});
    tv.push_back('{1, -32, 0});
    tv.push_back('{1, 31, 0});
    tv.push_back('{1, -33, -1});
    tv.push_back('{2, 127, 127});
    tv.push_back('{2, 127, 127});
    tv.push_back('{2, 127, 127});
    tv.push_back('{2, -128, 127});
    tv.push_back('{2, -128, -128});
    tv.push_back('{2, -128, -128});

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", int'(ov[0]), 0);
    chk("rst_out_data", int'(od[0]), 0);
    chk("rst_in_ready", int'(ir[0]), 1);

    foreach (tv[i]) begin
      send(tv[i].k, tv[i].y, got, lat);
      chk($sformatf("vec%0d", i), got, tv[i].exp);
      chk($sformatf("lat%0d", i), lat, 4);
      if (tv[i].k == 0) begin
        h2 = h1;
        h1 = tv[i].y;
      end
    end

    orr[0] = 1'b0;
    iv[0] = 1'b1;
    id[0] = 8'd100;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("bp_valid", int'(ov[0]), 1);
    v0 = int'($signed(od[0]));
    chk("bp_data", v0, dmodel(100));
    h2 = h1;
    h1 = 100;
    iv[0] = 1'b1;
    id[0] = 8'd55;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", int'(ov[0]), 1);
      chk("bp_hold_data", int'($signed(od[0])), v0);
      chk("bp_hold_ready", int'(ir[0]), 0);
    end
    iv[0] = 1'b0;
    orr[0] = 1'b1;
    @(negedge clk);
    chk("bp_idle_ready", int'(ir[0]), 1);
    chk("bp_idle_valid", int'(ov[0]), 0);
    send(0, 0, got, lat);
    chk("bp_next", got, dmodel(0));
    h2 = h1;
    h1 = 0;

    for (int i = 0; i < 40; i++) begin
      y = int'($urandom_range(0, 255)) - 128;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      e = dmodel(y);
      send(0, y, got, lat);
      chk($sformatf("rnd%0d_y%0d", i, y), got, e);
      chk("rnd_lat", lat, 4);
      h2 = h1;
      h1 = y;
    end

    foreach (tv[i]) begin
      if (i < 2) begin
        y = (i == 0) ? 50 : -70;
        e = dmodel(y);
        send(0, y, got, lat);
        chk("mid_pre", got, e);
        h2 = h1;
        h1 = y;
      end
    end
    iv[0] = 1'b1;
    id[0] = 8'd30;
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_out_valid", int'(ov[0]), 0);
    chk("mid_out_data", int'(od[0]), 0);
    chk("mid_in_ready", int'(ir[0]), 1);
    reset = 1'b0;
    h1 = 0;
    h2 = 0;
    @(negedge clk);
    send(0, 64, got, lat);
    chk("mid_post0", got, 64);
    send(0, 0, got, lat);
    chk("mid_post1", got, -20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/projfilt_inv.md
Name: projfilt_inv

Overview:
- Sequential 3-tap FIR "inverse/whitening" filter, the analysis counterpart of the team's 2nd-order recursive synthesis filter.
- Computes x[n] = C0*y[n] + C1*y[n-1] + C2*y[n-2], which undoes the recursion denominator.
- Uses one time-multiplexed multiplier, three MAC cycles per sample.
- Sits after the synthesis filter (or channel) on a valid/ready stream and feeds downstream consumers.

Parameters:
- C0, 8'sh40, tap 0 coefficient, signed Q2.6 (default = 1.0)
- C1, 8'shEC, tap 1 coefficient, signed Q2.6 (default = -0.3125, approx. -b1)
- C2, 8'sh09, tap 2 coefficient, signed Q2.6 (default = 0.140625, approx. -b2)
- FRAC, 6, fractional bits of the coefficients; right-shift applied to the accumulator

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  in_data holds a sample
- in_ready  out  1  block can accept a sample
- in_data  in  8  signed sample y[n], Q0.7 / integer
- out_valid  out  1  out_data holds a result
- out_ready  in  1  downstream accepts the result
- out_data  out  8  signed filtered sample x[n]

Behaviour:
- Reset: synchronous, active-high, on clk. Clears the following and forces state IDLE:
  - in_ready=1 after reset, out_valid=0, out_data=0
  - delay line d1=d2=0, sample latch s0=0, accumulator=0
- States: IDLE -> MAC0 -> MAC1 -> MAC2 -> OUT -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: s0<=in_data, acc<=0, go to MAC0.
- MAC0: acc += C0*s0. MAC1: acc += C1*d1. MAC2: acc += C2*d2.
  - At the end of MAC2: d2<=d1, d1<=s0. The delay line advances exactly once per accepted sample.
- OUT:
  - out_valid=1, out_data = sat8(round(acc)).
  - Held stable while out_ready=0.
  - When out_ready=1, the transfer completes that cycle and the next state is IDLE.
- in_ready=1 only in IDLE. Inputs presented in other states are ignored, with no side effects.
- Latency: sample accepted in cycle t -> out_valid first asserted in cycle t+4.
- Minimum throughput: one sample per 5 cycles when out_ready is held high.
- Arithmetic:
  - Product: 8x8 signed -> 16-bit signed.
  - Accumulator: 18-bit signed; no overflow is possible for 3 terms.
  - round: q = (acc >>> FRAC) + acc[FRAC-1], i.e. round half toward +inf.
  - sat8: clamp q to [-128, 127].
  - out_data is registered in the MAC2->OUT transition.
- Reset mid-operation: any state -> IDLE next cycle. A partial result is discarded and the delay line is cleared.
- out_ready high while not in OUT: ignored.

Decomposition:
- Shared package projfilt_pkg holds:
  - the state enum (IDLE, MAC0, MAC1, MAC2, OUT)
  - SAMPLE_W=8, PROD_W=16, ACC_W=18
  - default coefficient constants
- One sub-module, round_sat8: combinational, takes the ACC_W accumulator and FRAC, produces the rounded, saturated 8-bit value. It is reusable by the synthesis filter.
- The controller and datapath stay in projfilt_inv.

Test Plan:
- Impulse, default coefficients, out_ready=1:
  - stimulus: samples 64, 0, 0, 0
  - required: out_data 64, -20, 9, 0
  - each out_valid rises exactly 4 cycles after its accept
- Rounding, C0=1, C1=C2=0:
  - y=32 -> 1
  - y=-32 -> 0
  - y=31 -> 0
  - y=-33 -> -1
- Saturation, C0=C1=C2=127:
  - stimulus: three samples of 127
  - required: 3rd output = 127 (acc=48387)
  - same with three samples of -128: 3rd output = -128
- Backpressure:
  - hold out_ready=0 for 10 cycles in OUT: out_valid and out_data stable, in_ready=0
  - a new in_valid in that window is not consumed
  - release out_ready: the next sample is accepted in IDLE
- Reset mid-op, default coefficients:
  - after two samples, assert reset during MAC1 of the third sample
  - required: out_valid=0, out_data=0, in_ready=1 the next cycle
  - next sample 64 -> 64, then 0 -> -20 (delay line proves cleared)
